sseg_mux_hex: RTL and testbench

- Time-multiplexed, parametrised hex driver for a common-anode multi-digit seven-segment display (active-low segments and anodes).
- Accepts a packed NUM_DIGITS-nibble value, latches it tear-free at frame boundaries, and scans one digit per refresh slot.
- Per-digit decimal points, digit enables, optional leading-zero blanking, and an inter-digit ghosting blank.
- Sits between datapath/top-level and board pins; successor to the single-digit combinational hex decoder.

---
 rtl/sseg_mux_hex.sv | 182 ++++++++++++++++++
 tb/tb_sseg_mux_hex.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_hex.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// Frame-synchronous value latch, per-digit enables and decimal points, leading-zero and ghost blanking.
module sseg_mux_hex #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] pend;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_flag;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_lead_zero;
  logic                    suppress;
  logic                    past_blank;
  logic                    lit;

  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == LAST_CNT);
  assign frame_end = slot_end && (idx == LAST_IDX);

  // Slot timer and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (load) begin
        pend    <= value;
        pend_dp <= dp_in;
      end
      if (frame_end)
        pend_flag <= 1'b0;
      else if (load)
        pend_flag <= 1'b1;
    end
  end

  // A load landing on the boundary cycle bypasses the pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp    <= '0;
      disp_dp <= '0;
    end else if (frame_end) begin
      if (load) begin
        disp    <= value;
        disp_dp <= dp_in;
      end else if (pend_flag) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
    end
  end

  // lead_zero[i]: every displayed nibble from the top down to i is zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib       = 4'h0;
    cur_dp        = 1'b0;
    cur_en        = 1'b0;
    cur_lead_zero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = disp[4*i +: 4];
        cur_dp        = disp_dp[i];
        cur_en        = digit_en[i];
        cur_lead_zero = lead_zero[i];
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt >= BLANK_END);
    end
  endgenerate

  assign suppress = lz_blank && (idx != '0) && cur_lead_zero;
  assign lit      = past_blank && cur_en && !suppress;

  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (lit) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = hex_decode(cur_nib);
      dp_next  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sseg_mux_hex.sv
// Scoreboard bench for sseg_mux_hex: a time-indexed reference model predicts every output
// register update; a monitor pops and compares after each rising edge.
module tb_sseg_mux_hex;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic          clk;
  logic          reset;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  sseg_mux_hex #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time since reset, displayed word, pending word
  int          t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_flag;
  logic [3:0]  cur_en;
  bit          cur_lz;

  function automatic out_t predict(input logic [3:0] en, input bit lz);
    out_t o;
    int slot_pos, d;
    bit hidden;
    slot_pos = t % RD;
    d        = (t / RD) % ND;
    hidden   = lz && d > 0 && ((m_disp >> (4 * d)) == 16'h0);
    o = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    if (slot_pos >= BC && en[d] && !hidden) begin
      o.an  = 4'hF & ~(4'(1) << d);
      o.seg = seg_tab[(m_disp >> (4 * d)) & 16'hF];
      o.dp  = ~m_disp_dp[d];
    end
    return o;
  endfunction

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_flag = 0;
  endtask

  // Apply inputs for the coming edge, predict its output, advance the model past it.
  task automatic apply(input bit ld, input logic [15:0] v, input logic [3:0] d);
    bit boundary;
    load = ld; value = v; dp_in = d; digit_en = cur_en; lz_blank = cur_lz;
    exp_q.push_back(predict(cur_en, cur_lz));
    boundary = (t % FRAME) == FRAME - 1;
    if (boundary) begin
      if (ld) begin m_disp = v; m_disp_dp = d; end
      else if (m_flag) begin m_disp = m_pend; m_disp_dp = m_pend_dp; end
    end
    if (ld) begin m_pend = v; m_pend_dp = d; end
    m_flag = boundary ? 1'b0 : (ld ? 1'b1 : m_flag);
    t++;
  endtask

  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    apply(ld, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic check_out(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, t, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
    end
  endtask

  // Monitor: the output register updates every edge, so each edge consumes one prediction.
  initial begin
    out_t w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_out("scan", '{an: an, seg: seg, dp: dp}, w);
      end
    end
  end

  task automatic wait_phase(input int phase);
    int n;
    n = 0;
    while ((t % FRAME) != phase && n < 2 * FRAME) begin
      idle(1);
      n++;
    end
    checks++;
    if ((t % FRAME) != phase) begin
      errors++;
      $display("FAIL align: phase=%0d expected %0d", t % FRAME, phase);
    end
  endtask

  localparam out_t DARK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  initial begin
    int lit;
    int n_rand;
    logic [15:0] mask;
    reset = 1'b1; load = 0; value = '0; dp_in = '0; digit_en = 4'hF; lz_blank = 0;
    cur_en = 4'hF; cur_lz = 0;
    model_reset();
    #22;
    check_out("reset_state", '{an: an, seg: seg, dp: dp}, DARK);

    // Release and verify the blanking duty over frame 0
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 16'h0, 4'h0);
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, 4'h0);
      if (an != 4'hF) lit++;
    end
    checks++;
    if (lit != ND * (RD - BC)) begin
      errors++;
      $display("FAIL lit_duty: got %0d lit clocks, expected %0d", lit, ND * (RD - BC));
    end

    // Mid-frame load must not tear the current frame
    wait_phase(13);
    step(1'b1, 16'h1A2F, 4'b0100);
    idle(2 * FRAME);

    // Leading-zero blanking
    cur_lz = 1;
    step(1'b1, 16'h0000, 4'h0);
    idle(2 * FRAME);
    step(1'b1, 16'h00F0, 4'h0);
    idle(2 * FRAME);
    cur_lz = 0;

    // Digit enable mask
    cur_en = 4'b1011;
    idle(FRAME + 3);
    cur_en = 4'hF;

    // Pending 9999 overtaken by a load exactly on the boundary cycle
    wait_phase(5);
    step(1'b1, 16'h9999, 4'h0);
    wait_phase(FRAME - 1);
    step(1'b1, 16'h5555, 4'b1111);
    idle(2 * FRAME);

    // Pending load then async reset mid-slot on digit 2
    step(1'b1, 16'h7777, 4'h0);
    wait_phase(2 * RD + 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", '{an: an, seg: seg, dp: dp}, DARK);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_out("reset_hold", '{an: an, seg: seg, dp: dp}, DARK);
    reset = 1'b0;
    apply(1'b0, 16'h0, 4'h0);
    idle(2 * FRAME);

    // Randomised traffic
    n_rand = 800;
    for (int i = 0; i < n_rand; i++) begin
      if ($urandom_range(0, 39) == 0) cur_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      if ($urandom_range(0, 11) == 0)
        step(1'b1, 16'($urandom) & mask, 4'($urandom_range(0, 15)));
      else
        step(1'b0, 16'($urandom), 4'($urandom_range(0, 15)));
    end
    load = 0;

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
